// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_pkg
//  Purpose  : Shared definitions for the SIPO serial receiver family:
//             default word width, bit-counter type and frame-length helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package sipo_pkg;

   localparam int SIPO_DEFAULT_WIDTH = 8;
   localparam int SIPO_MAX_WIDTH     = 32;

   // Wide enough for the longest legal frame (32 data bits plus parity).
   // Individual receivers may size their own counter tighter.
   localparam int SIPO_CNT_W = $clog2(SIPO_MAX_WIDTH + 2);
   typedef logic [SIPO_CNT_W-1:0] sipo_cnt_t;

   // Number of enabled bit samples that make up one word on the wire.
   function automatic int sipo_frame_len(input int width, input bit parity_en);
      return parity_en ? width + 1 : width;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sipo_shreg.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_shreg
//  Purpose  : WIDTH-bit left-shifting register (new bit enters at LSB) with
//             clock enable and synchronous clear. Clear beats enable.
//  Ports    : i_clk   - clock, rising edge
//             i_rst   - asynchronous active-high reset
//             i_ce    - shift enable
//             i_clear - synchronous clear to zero
//             i_si    - serial input bit
//             o_q     - current register contents
//  Revision : 1.0  initial release
// ============================================================================
module sipo_shreg
   import sipo_pkg::*;
#(
   parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_ce,
   input  logic             i_clear,
   input  logic             i_si,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_sr;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sr <= '0;
      end else if (i_clear) begin
         r_sr <= '0;
      end else if (i_ce) begin
         r_sr <= {r_sr[WIDTH-2:0], i_si};
      end
   end

   assign o_q = r_sr;

endmodule
`default_nettype wire

// File: rtl/sipo_rx.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_rx
//  Purpose  : Serial-in / parallel-out receiver. Samples i_si MSB first on
//             each enabled clock, assembles WIDTH-bit words and presents each
//             completed word on a held output with a one-cycle valid strobe.
//             Optional even-parity bit after the data LSB when the macro
//             SIPO_RX_PARITY_EN is defined (adds port o_perr).
//  Ports    : i_clk      - clock, rising edge
//             i_rst      - asynchronous active-high reset
//             i_si       - serial data bit
//             i_ce       - bit strobe, i_si sampled only when high
//             i_clear    - synchronous resync, discards the partial word
//             o_po       - last completed word, held until the next one
//             o_po_valid - one-cycle pulse when o_po is updated
//             o_busy     - a partial word is in progress
//             o_perr     - parity error of the word on o_po (parity build)
//  Revision : 1.0  initial release
// ============================================================================
module sipo_rx
   import sipo_pkg::*;
#(
   parameter int WIDTH = SIPO_DEFAULT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_si,
   input  logic             i_ce,
   input  logic             i_clear,
   output logic [WIDTH-1:0] o_po,
   output logic             o_po_valid,
   output logic             o_busy
`ifdef SIPO_RX_PARITY_EN
   ,
   output logic             o_perr
`endif
);

`ifdef SIPO_RX_PARITY_EN
   localparam bit c_PAR_EN = 1'b1;
`else
   localparam bit c_PAR_EN = 1'b0;
`endif

   localparam int                 c_FRAME = sipo_frame_len(WIDTH, c_PAR_EN);
   localparam int                 c_CNT_W = $clog2(WIDTH + 2);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_FRAME - 1);

   logic [c_CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0]   r_po;
   logic               r_po_valid;
   logic [WIDTH-1:0]   w_sr;
   logic [WIDTH-1:0]   w_word;
   logic               w_last;

   sipo_shreg #(
      .WIDTH (WIDTH)
   ) u_shreg (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_ce    (i_ce),
      .i_clear (i_clear),
      .i_si    (i_si),
      .o_q     (w_sr)
   );

   // Clear wins over the strobe, so a clear on the final bit yields no word.
   assign w_last = i_ce & ~i_clear & (r_cnt == c_LAST);

`ifdef SIPO_RX_PARITY_EN
   // Data is complete in the shift register when the parity bit arrives.
   assign w_word = w_sr;
`else
   // The last data bit is still on i_si; fold it in at the completing edge.
   logic w_unused_msb;
   assign w_word       = {w_sr[WIDTH-2:0], i_si};
   assign w_unused_msb = w_sr[WIDTH-1];
`endif

   // Bit counter: wraps to zero on the completing edge so the next word's
   // first bit can be taken on the very next enabled edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_ce) begin
         if (r_cnt == c_LAST) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_po       <= '0;
         r_po_valid <= 1'b0;
      end else begin
         r_po_valid <= w_last;
         if (w_last) begin
            r_po <= w_word;
         end
      end
   end

`ifdef SIPO_RX_PARITY_EN
   logic r_perr;

   // Even parity: XOR over data plus parity bit must be zero.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_perr <= 1'b0;
      end else if (w_last) begin
         r_perr <= ^{w_sr, i_si};
      end
   end

   assign o_perr = r_perr;
`endif

   assign o_po       = r_po;
   assign o_po_valid = r_po_valid;
   assign o_busy     = (r_cnt != '0);

endmodule
`default_nettype wire
